// File: rtl/exc_intr_ctrl.sv
// MEM-stage exception/interrupt controller: synchronises hw interrupts, prioritises traps,
// issues a one-cycle registered flush/redirect and then masks events for a short shadow window.
module exc_intr_ctrl #(
  parameter int          N_HW_IRQ     = 6,
  parameter int          SYNC_STAGES  = 2,
  parameter int          FLUSH_SHADOW = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_m,
  input  logic                stall_m,
  input  logic                ri,
  input  logic                break_m,
  input  logic                syscall,
  input  logic                overflow,
  input  logic                addr_err_sw,
  input  logic                addr_err_lw,
  input  logic                pc_err,
  input  logic                eret_m,
  input  logic                is_bd_m,
  input  logic [N_HW_IRQ-1:0] hw_int,
  input  logic [31:0]         cp0_status,
  input  logic [31:0]         cp0_cause,
  input  logic [31:0]         cp0_epc,
  input  logic [31:0]         pc_m,
  input  logic [31:0]         alu_out_m,
  output logic [N_HW_IRQ-1:0] hw_ip,
  output logic [31:0]         except_type,
  output logic                pc_trap,
  output logic                flush_exception,
  output logic [31:0]         pc_exception,
  output logic [31:0]         badvaddr,
  output logic [31:0]         epc_out,
  output logic                bd_out,
  output logic                busy
);

  localparam logic [31:0] EXC_TYPE_NOEXC = 32'h0000_0000;
  localparam logic [31:0] EXC_TYPE_INT   = 32'h0000_0001;
  localparam logic [31:0] EXC_TYPE_ADEL  = 32'h0000_0004;
  localparam logic [31:0] EXC_TYPE_ADES  = 32'h0000_0005;
  localparam logic [31:0] EXC_TYPE_SYS   = 32'h0000_0008;
  localparam logic [31:0] EXC_TYPE_BP    = 32'h0000_0009;
  localparam logic [31:0] EXC_TYPE_RI    = 32'h0000_000a;
  localparam logic [31:0] EXC_TYPE_OV    = 32'h0000_000c;
  localparam logic [31:0] EXC_TYPE_ERET  = 32'h0000_000e;

  localparam logic [3:0] SHADOW_LOAD = 4'(FLUSH_SHADOW);

  typedef enum logic [1:0] {IDLE, TRAP, SHADOW} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [N_HW_IRQ-1:0]   sync_q [SYNC_STAGES];
  logic [31:0]           except_type_q, pc_exception_q, badvaddr_q, epc_out_q;
  logic                  bd_out_q;
  logic [31:0]           type_d;
  logic [N_HW_IRQ+1:0]   ip_all;
  logic                  irq, any_flag, event_w, load;
  logic                  unused_bits;

  assign unused_bits = ^{cp0_status, cp0_cause};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign hw_ip = sync_q[SYNC_STAGES-1];

  // Hardware IP bits come from the local synchroniser, not from the (lagging) Cause copy.
  assign ip_all   = {hw_ip, cp0_cause[9:8]};
  assign irq      = cp0_status[0] & ~cp0_status[1] & (|(ip_all & cp0_status[8 +: N_HW_IRQ+2]));
  assign any_flag = ri | break_m | syscall | overflow | addr_err_sw | addr_err_lw | pc_err | eret_m;
  assign event_w  = valid_m & (irq | any_flag);

  always_comb begin
    type_d = EXC_TYPE_NOEXC;
    if (irq)                        type_d = EXC_TYPE_INT;
    else if (addr_err_lw || pc_err) type_d = EXC_TYPE_ADEL;
    else if (ri)                    type_d = EXC_TYPE_RI;
    else if (syscall)               type_d = EXC_TYPE_SYS;
    else if (break_m)               type_d = EXC_TYPE_BP;
    else if (addr_err_sw)           type_d = EXC_TYPE_ADES;
    else if (overflow)              type_d = EXC_TYPE_OV;
    else if (eret_m)                type_d = EXC_TYPE_ERET;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (event_w && !stall_m) begin
          state_d = TRAP;
          load    = 1'b1;
        end
      end
      TRAP: begin
        cnt_d   = SHADOW_LOAD;
        state_d = (FLUSH_SHADOW > 0) ? SHADOW : IDLE;
      end
      SHADOW: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      except_type_q  <= EXC_TYPE_NOEXC;
      pc_exception_q <= 32'h0;
      badvaddr_q     <= 32'h0;
      epc_out_q      <= 32'h0;
      bd_out_q       <= 1'b0;
    end else if (load) begin
      except_type_q  <= type_d;
      pc_exception_q <= (type_d == EXC_TYPE_ERET) ? cp0_epc : EXC_VECTOR;
      badvaddr_q     <= pc_err ? pc_m : alu_out_m;
      epc_out_q      <= is_bd_m ? (pc_m - 32'd4) : pc_m;
      bd_out_q       <= is_bd_m;
    end
  end

  assign except_type     = except_type_q;
  assign pc_exception    = pc_exception_q;
  assign badvaddr        = badvaddr_q;
  assign epc_out         = epc_out_q;
  assign bd_out          = bd_out_q;
  assign pc_trap         = (state_q == TRAP);
  assign flush_exception = (state_q == TRAP);
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_exc_intr_ctrl.sv
// Directed bench for exc_intr_ctrl: hand-computed expectations for trap type, target, timing and shadow.
module tb_exc_intr_ctrl;

  localparam logic [31:0] T_NOEXC = 32'h0, T_INT = 32'h1, T_ADEL = 32'h4, T_SYS = 32'h8;
  localparam logic [31:0] T_BP = 32'h9, T_RI = 32'ha, T_OV = 32'hc, T_ERET = 32'he;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_m, stall_m, ri, break_m, syscall, overflow;
  logic        addr_err_sw, addr_err_lw, pc_err, eret_m, is_bd_m;
  logic [5:0]  hw_int;
  logic [31:0] cp0_status, cp0_cause, cp0_epc, pc_m, alu_out_m;
  logic [5:0]  hw_ip;
  logic [31:0] except_type, pc_exception, badvaddr, epc_out;
  logic        pc_trap, flush_exception, bd_out, busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exc_intr_ctrl dut (
    .clk(clk), .rst(rst), .valid_m(valid_m), .stall_m(stall_m), .ri(ri), .break_m(break_m),
    .syscall(syscall), .overflow(overflow), .addr_err_sw(addr_err_sw), .addr_err_lw(addr_err_lw),
    .pc_err(pc_err), .eret_m(eret_m), .is_bd_m(is_bd_m), .hw_int(hw_int),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc), .pc_m(pc_m),
    .alu_out_m(alu_out_m), .hw_ip(hw_ip), .except_type(except_type), .pc_trap(pc_trap),
    .flush_exception(flush_exception), .pc_exception(pc_exception), .badvaddr(badvaddr),
    .epc_out(epc_out), .bd_out(bd_out), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    valid_m = 0; stall_m = 0; ri = 0; break_m = 0; syscall = 0; overflow = 0;
    addr_err_sw = 0; addr_err_lw = 0; pc_err = 0; eret_m = 0; is_bd_m = 0;
  endtask

  task automatic drain();
    clear_flags();
    repeat (3) step();
    check("drain_busy", 32'(busy), 0);
  endtask

  initial begin
    rst = 0; clear_flags();
    hw_int = 0; cp0_status = 0; cp0_cause = 0; cp0_epc = 0; pc_m = 0; alu_out_m = 0;
    repeat (2) step();
    check("rst_trap", 32'(pc_trap), 0);
    check("rst_flush", 32'(flush_exception), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_type", except_type, T_NOEXC);
    check("rst_pcexc", pc_exception, 0);
    check("rst_hwip", 32'(hw_ip), 0);
    rst = 1;
    step();

    // RI trap, one-cycle strobe, shadow length
    valid_m = 1; ri = 1; pc_m = 32'hBFC0_0100;
    step();
    check("ri_trap", 32'(pc_trap), 1);
    check("ri_flush", 32'(flush_exception), 1);
    check("ri_type", except_type, T_RI);
    check("ri_target", pc_exception, VEC);
    check("ri_epc", epc_out, 32'hBFC0_0100);
    check("ri_bd", 32'(bd_out), 0);
    clear_flags();
    step();
    check("ri_trap_gone", 32'(pc_trap), 0);
    check("ri_shadow_busy1", 32'(busy), 1);
    step();
    check("ri_shadow_busy2", 32'(busy), 1);
    step();
    check("ri_idle", 32'(busy), 0);

    // Hardware interrupt through the synchroniser
    cp0_status = 32'h0000_0401; valid_m = 1; pc_m = 32'h0000_4000; hw_int = 6'b000001;
    step();
    check("int_hwip_s1", 32'(hw_ip), 0);
    check("int_notrap_s1", 32'(pc_trap), 0);
    step();
    check("int_hwip_s2", 32'(hw_ip), 1);
    check("int_notrap_s2", 32'(pc_trap), 0);
    step();
    check("int_trap", 32'(pc_trap), 1);
    check("int_type", except_type, T_INT);
    hw_int = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("int_deassert_notrap", 32'(pc_trap), 0);
    end
    cp0_status = 32'h0000_0403; hw_int = 6'b000001;
    for (int i = 0; i < 4; i++) begin
      step();
      check("int_exl_notrap", 32'(pc_trap), 0);
    end
    hw_int = 0; cp0_status = 0;
    drain();

    // ERET, then ERET losing to overflow
    valid_m = 1; eret_m = 1; cp0_epc = 32'h8000_1234;
    step();
    check("eret_trap", 32'(pc_trap), 1);
    check("eret_type", except_type, T_ERET);
    check("eret_target", pc_exception, 32'h8000_1234);
    drain();
    valid_m = 1; eret_m = 1; overflow = 1;
    step();
    check("eret_ov_type", except_type, T_OV);
    check("eret_ov_target", pc_exception, VEC);
    drain();

    // Load address error held off by stall
    valid_m = 1; addr_err_lw = 1; stall_m = 1; alu_out_m = 32'h1234_5679;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_notrap", 32'(pc_trap), 0);
    end
    stall_m = 0;
    step();
    check("adel_trap", 32'(pc_trap), 1);
    check("adel_type", except_type, T_ADEL);
    check("adel_badvaddr", badvaddr, 32'h1234_5679);
    drain();

    // Shadow swallows a short flag, not a long one
    valid_m = 1; syscall = 1;
    step();
    check("sys_type", except_type, T_SYS);
    syscall = 0; overflow = 1;
    step();
    check("shadow_a_busy", 32'(busy), 1);
    step();
    check("shadow_b_busy", 32'(busy), 1);
    overflow = 0;
    step();
    check("shadow_c_idle", 32'(busy), 0);
    step();
    check("shadow_short_notrap", 32'(pc_trap), 0);
    check("shadow_short_type", except_type, T_SYS);
    drain();
    valid_m = 1; syscall = 1;
    step();
    syscall = 0; overflow = 1;
    repeat (3) step();
    check("shadow_long_wait", 32'(pc_trap), 0);
    step();
    check("shadow_long_trap", 32'(pc_trap), 1);
    check("shadow_long_type", except_type, T_OV);
    drain();

    // Soft interrupt beats RI; EPC is the instruction itself
    cp0_status = 32'h0000_0101; cp0_cause = 32'h0000_0100;
    valid_m = 1; ri = 1; pc_m = 32'h0000_0100;
    step();
    check("prio_type", except_type, T_INT);
    check("prio_epc", epc_out, 32'h0000_0100);
    cp0_status = 0; cp0_cause = 0;
    drain();

    // Break in delay slot at pc 0: EPC wraps
    valid_m = 1; break_m = 1; is_bd_m = 1; pc_m = 32'h0;
    step();
    check("bp_type", except_type, T_BP);
    check("bp_epc_wrap", epc_out, 32'hFFFF_FFFC);
    drain();

    // PC error in delay slot, then reset mid-TRAP
    valid_m = 1; pc_err = 1; is_bd_m = 1; pc_m = 32'h0000_0002; alu_out_m = 32'h0000_DEAD;
    step();
    check("pcerr_trap", 32'(pc_trap), 1);
    check("pcerr_type", except_type, T_ADEL);
    check("pcerr_badvaddr", badvaddr, 32'h0000_0002);
    check("pcerr_epc", epc_out, 32'hFFFF_FFFE);
    check("pcerr_bd", 32'(bd_out), 1);
    rst = 0;
    #1;
    check("rstmid_trap", 32'(pc_trap), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_type", except_type, T_NOEXC);
    check("rstmid_epc", epc_out, 0);
    clear_flags();
    step();
    check("rstmid_held", 32'(pc_trap), 0);
    rst = 1;
    step();
    check("post_rst_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
